// File: rtl/seq_mult.sv
// Iterative shift-add multiplier: one partial-product add per clock, signed or unsigned
// per operation, result in the (2*WIDTH+1)-bit array-multiplier format.
module seq_mult #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [2*WIDTH:0] ans
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic                 smode_q, smode_d;
    logic                 done_q, done_d;
    logic [2*WIDTH:0]     ans_q, ans_d;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [2*WIDTH-1:0]   res;

    // Magnitude of the most negative value still fits in WIDTH unsigned bits.
    always_comb begin
        a_mag = (signed_mode && a[WIDTH-1]) ? -a : a;
        b_mag = (signed_mode && b[WIDTH-1]) ? -b : b;
        res   = neg_q ? -acc_q : acc_q;
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        smode_d  = smode_q;
        ans_d    = ans_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mcand_d  = {{WIDTH{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    acc_d    = '0;
                    cnt_d    = '0;
                    neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                    smode_d  = signed_mode;
                    state_d  = StRun;
                end
            end
            StRun: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                ans_d   = {smode_q & res[2*WIDTH-1], res};
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            smode_q  <= 1'b0;
            done_q   <= 1'b0;
            ans_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            smode_q  <= smode_d;
            done_q   <= done_d;
            ans_q    <= ans_d;
        end
    end

    assign busy = (state_q == StRun);
    assign done = done_q;
    assign ans  = ans_q;

endmodule

// File: tb/tb_seq_mult.sv
// Directed bench for seq_mult: 32-bit and 8-bit instances, corner products, start-while-busy,
// asynchronous reset mid-operation and a short seeded model-checked sweep.
module tb_seq_mult;

    logic        clk = 1'b0;
    logic        rst;
    logic        start32, sm32, start8, sm8;
    logic [31:0] a32, b32;
    logic [7:0]  a8, b8;
    logic        busy32, done32, busy8, done8;
    logic [64:0] ans32;
    logic [16:0] ans8;

    int checks   = 0;
    int failures = 0;

    bit          sel8 = 1'b0;
    logic        busy_s, done_s;
    logic [64:0] ans_s;

    assign busy_s = sel8 ? busy8 : busy32;
    assign done_s = sel8 ? done8 : done32;
    assign ans_s  = sel8 ? {48'b0, ans8} : ans32;

    always #5 clk = ~clk;

    seq_mult #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .start(start32), .signed_mode(sm32),
        .a(a32), .b(b32), .busy(busy32), .done(done32), .ans(ans32)
    );

    seq_mult #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .ans(ans8)
    );

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference product, sign-extended to the instance's 2W+1 result width.
    function automatic logic [64:0] model(input logic [31:0] av, input logic [31:0] bv,
                                          input bit sm, input int w);
        logic signed [64:0] x, y, p;
        x = 65'(av);
        y = 65'(bv);
        if (sm && av[w-1]) x = x - (65'sd1 <<< w);
        if (sm && bv[w-1]) y = y - (65'sd1 <<< w);
        p = x * y;
        if (w == 8) p = p & 65'h1FFFF;
        return p;
    endfunction

    task automatic run_op(input bit w8, input logic [31:0] av, input logic [31:0] bv,
                          input bit sm, input logic [64:0] expv, input string tag);
        int lat;
        int w;
        sel8 = w8;
        w    = w8 ? 8 : 32;
        if (w8) begin
            a8 = av[7:0]; b8 = bv[7:0]; sm8 = sm; start8 = 1'b1;
        end else begin
            a32 = av; b32 = bv; sm32 = sm; start32 = 1'b1;
        end
        tick;
        start8  = 1'b0;
        start32 = 1'b0;
        // Scramble operands after capture; they must not matter.
        a8  = ~a8;  b8  = ~b8;  sm8  = ~sm8;
        a32 = ~a32; b32 = ~b32; sm32 = ~sm32;
        check({tag, "/busy"}, 65'(busy_s), 65'd1);
        lat = 0;
        while (done_s !== 1'b1 && lat < 100) begin
            tick;
            lat++;
        end
        check({tag, "/latency"}, 65'(lat), 65'(w + 1));
        check({tag, "/ans"}, ans_s, expv);
        tick;
        check({tag, "/done_low"}, 65'(done_s), 65'd0);
        check({tag, "/hold"}, ans_s, expv);
    endtask

    initial begin
        int          ndone;
        int          lat;
        logic [31:0] ra, rb;
        bit          rw8, rsm;

        rst = 1'b1;
        start32 = 1'b0; sm32 = 1'b0; a32 = '0; b32 = '0;
        start8  = 1'b0; sm8  = 1'b0; a8  = '0; b8  = '0;
        #12;
        check("reset/ans32", ans32, 65'd0);
        check("reset/busy32", 65'(busy32), 65'd0);
        check("reset/done32", 65'(done32), 65'd0);
        check("reset/ans8", 65'(ans8), 65'd0);
        @(negedge clk);
        rst = 1'b0;
        tick;

        run_op(0, 32'hFFFF_FFFB, 32'h0, 1'b1, 65'd0, "s32_negxzero");
        run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 65'h0_FFFF_FFFE_0000_0001, "u32_max");
        run_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 65'h1_FFFF_FFFF_FFFF_FFFF, "s32_m1x1");
        run_op(0, 32'h8000_0000, 32'h8000_0000, 1'b1, 65'h0_4000_0000_0000_0000, "s32_minxmin");
        run_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 65'h0_0000_0000_8000_0000, "s32_minxm1");
        run_op(1, 32'hFF, 32'hFF, 1'b0, 65'h0FE01, "u8_max");
        run_op(1, 32'h80, 32'h7F, 1'b1, 65'h1C080, "s8_minxmax");

        // Start held with changing operands through RUN and FIN.
        sel8 = 1'b1;
        a8 = 8'd3; b8 = 8'd5; sm8 = 1'b0; start8 = 1'b1;
        tick;
        ndone = 0;
        for (int i = 1; i <= 9; i++) begin
            a8 = 8'(i * 17); b8 = 8'(i * 29); sm8 = i[0];
            tick;
            if (done8 === 1'b1) ndone++;
        end
        check("busy_start/ndone", 65'(ndone), 65'd1);
        check("busy_start/done", 65'(done8), 65'd1);
        check("busy_start/ans", 65'(ans8), 65'd15);
        a8 = 8'd7; b8 = 8'd9; sm8 = 1'b0;
        tick;
        start8 = 1'b0;
        check("b2b/busy", 65'(busy8), 65'd1);
        lat = 0;
        while (done8 !== 1'b1 && lat < 100) begin
            tick;
            lat++;
        end
        check("b2b/latency", 65'(lat), 65'd9);
        check("b2b/ans", 65'(ans8), 65'd63);

        // Asynchronous reset on the tenth RUN cycle.
        sel8 = 1'b0;
        a32 = 32'd12345; b32 = 32'd678; sm32 = 1'b0; start32 = 1'b1;
        tick;
        start32 = 1'b0;
        repeat (9) tick;
        #2 rst = 1'b1;
        #1;
        check("rst_mid/busy", 65'(busy32), 65'd0);
        check("rst_mid/done", 65'(done32), 65'd0);
        check("rst_mid/ans", ans32, 65'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (40) begin
            tick;
            if (done32 === 1'b1) ndone++;
        end
        check("rst_mid/no_done", 65'(ndone), 65'd0);
        run_op(0, 32'd12345, 32'd678, 1'b0, 65'd8369910, "rst_mid/restart");

        for (int i = 0; i < 40; i++) begin
            rw8 = i[0];
            rsm = i[1];
            ra  = $urandom;
            rb  = $urandom;
            if (rw8) begin
                ra = {24'b0, ra[7:0]};
                rb = {24'b0, rb[7:0]};
            end
            run_op(rw8, ra, rb, rsm, model(ra, rb, rsm, rw8 ? 8 : 32), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
